// File: rtl/fp_ci_pkg.sv
// Shared types and constants for the floating-point custom-instruction issuer.
// Holds the FSM state enum, the quiet-NaN timeout payload and the debug struct.
package fp_ci_pkg;

    localparam int FP_W = 32;
    localparam int CNT_W = 16;

    typedef logic [FP_W-1:0] fp_word_t;
    typedef logic [CNT_W-1:0] fp_cnt_t;

    localparam fp_word_t FP_QNAN = 32'h7FC0_0000;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_HOLD  = 2'd3
    } fp_ci_state_e;

    typedef struct packed {
        fp_ci_state_e state;
        fp_cnt_t      wait_cnt;
        logic         done_ok;
        logic         timeout;
    } fp_ci_dbg_t;

    // Statistics counters roll over from 16'hFFFF back to zero.
    function automatic fp_cnt_t cnt_wrap_inc(input fp_cnt_t c);
        return c + fp_cnt_t'(1);
    endfunction

endpackage

// File: rtl/fp_ci_issuer_if.sv
// Bundle of the operand, FP-unit and result channels of the issuer.
// master = issuer side, slave = surrounding system (producer, FP unit, consumer).
interface fp_ci_issuer_if;
    import fp_ci_pkg::*;

    // Operand and result channels use valid/ready: a transfer happens on a rising
    // edge where both are high; valid, once raised, holds its payload stable until
    // that transfer, and ready may depend on state but never on valid.
    logic     in_valid;
    logic     in_ready;
    fp_word_t in_dataa;
    fp_word_t in_datab;

    logic     ci_start;
    fp_word_t ci_dataa;
    fp_word_t ci_datab;
    fp_word_t ci_result;
    logic     ci_done;

    logic     out_valid;
    logic     out_ready;
    fp_word_t out_result;
    logic     out_timeout;

    fp_cnt_t  op_count;
    fp_cnt_t  to_count;

    modport master (
        input  in_valid, in_dataa, in_datab, ci_result, ci_done, out_ready,
        output in_ready, ci_start, ci_dataa, ci_datab,
               out_valid, out_result, out_timeout, op_count, to_count
    );

    modport slave (
        output in_valid, in_dataa, in_datab, ci_result, ci_done, out_ready,
        input  in_ready, ci_start, ci_dataa, ci_datab,
               out_valid, out_result, out_timeout, op_count, to_count
    );

endinterface

// File: rtl/fp_ci_wait_timer.sv
// Wait counter for one FP-unit operation: gates ci_done until MIN_LAT cycles
// have elapsed and flags a timeout once TIMEOUT_CYCLES is reached.
module fp_ci_wait_timer
    import fp_ci_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int MIN_LAT        = 2
) (
    input  logic    clk,
    input  logic    reset_n,
    input  logic    i_clear,
    input  logic    i_run,
    input  logic    i_done,
    output logic    o_done_ok,
    output logic    o_timeout,
    output fp_cnt_t o_count
);

    localparam int CMAX = (MIN_LAT > TIMEOUT_CYCLES) ? MIN_LAT : TIMEOUT_CYCLES;
    localparam int CW   = (CMAX < 2) ? 1 : $clog2(CMAX + 1);

    localparam logic [CW-1:0] C_MIN = CW'(MIN_LAT);
    localparam logic [CW-1:0] C_TO  = CW'(TIMEOUT_CYCLES);

    logic [CW-1:0] r_cnt;

    // Saturates at the timeout value so the counter can never wrap back below MIN_LAT.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt <= '0;
        end else if (i_clear) begin
            r_cnt <= '0;
        end else if (i_run && (r_cnt != C_TO)) begin
            r_cnt <= r_cnt + CW'(1);
        end
    end

    assign o_done_ok = i_run && i_done && (r_cnt >= C_MIN);
    assign o_timeout = i_run && (r_cnt >= C_TO);
    assign o_count   = CNT_W'(r_cnt);

endmodule

// File: rtl/fp_ci_issuer.sv
// Issues one operand pair at a time to a multi-cycle FP unit and returns its result,
// substituting a quiet NaN with out_timeout=1 when the unit never signals done.
module fp_ci_issuer
    import fp_ci_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int MIN_LAT        = 2
) (
    input  logic                  clk,
    input  logic                  reset_n,
    fp_ci_issuer_if.master        io_bus,
    output fp_ci_dbg_t            o_dbg
);

    fp_ci_state_e r_state;
    logic         r_in_ready;
    logic         r_ci_start;
    fp_word_t     r_ci_dataa;
    fp_word_t     r_ci_datab;
    logic         r_out_valid;
    fp_word_t     r_out_result;
    logic         r_out_timeout;
    fp_cnt_t      r_op_count;
    fp_cnt_t      r_to_count;

    logic         w_timer_clear;
    logic         w_timer_run;
    logic         w_done_ok;
    logic         w_timeout;
    fp_cnt_t      w_wait_cnt;

    assign w_timer_clear = (r_state == ST_ISSUE);
    assign w_timer_run   = (r_state == ST_WAIT);

    fp_ci_wait_timer #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .MIN_LAT        (MIN_LAT)
    ) u_timer (
        .clk       (clk),
        .reset_n   (reset_n),
        .i_clear   (w_timer_clear),
        .i_run     (w_timer_run),
        .i_done    (io_bus.ci_done),
        .o_done_ok (w_done_ok),
        .o_timeout (w_timeout),
        .o_count   (w_wait_cnt)
    );

    // Operands are only reloaded in IDLE, so they stay put for the unit from ISSUE through HOLD.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state       <= ST_IDLE;
            r_in_ready    <= 1'b1;
            r_ci_start    <= 1'b0;
            r_ci_dataa    <= '0;
            r_ci_datab    <= '0;
            r_out_valid   <= 1'b0;
            r_out_result  <= '0;
            r_out_timeout <= 1'b0;
            r_op_count    <= '0;
            r_to_count    <= '0;
        end else begin
            r_ci_start <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (io_bus.in_valid) begin
                        r_ci_dataa <= io_bus.in_dataa;
                        r_ci_datab <= io_bus.in_datab;
                        r_in_ready <= 1'b0;
                        r_ci_start <= 1'b1;
                        r_state    <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    r_state <= ST_WAIT;
                end
                ST_WAIT: begin
                    // A real result beats a timeout that lands in the same cycle.
                    if (w_done_ok) begin
                        r_out_result  <= io_bus.ci_result;
                        r_out_timeout <= 1'b0;
                        r_out_valid   <= 1'b1;
                        r_state       <= ST_HOLD;
                    end else if (w_timeout) begin
                        r_out_result  <= FP_QNAN;
                        r_out_timeout <= 1'b1;
                        r_out_valid   <= 1'b1;
                        r_state       <= ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (io_bus.out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_op_count  <= cnt_wrap_inc(r_op_count);
                        if (r_out_timeout) begin
                            r_to_count <= cnt_wrap_inc(r_to_count);
                        end
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_state     <= ST_IDLE;
                    r_in_ready  <= 1'b1;
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

    assign io_bus.in_ready    = r_in_ready;
    assign io_bus.ci_start    = r_ci_start;
    assign io_bus.ci_dataa    = r_ci_dataa;
    assign io_bus.ci_datab    = r_ci_datab;
    assign io_bus.out_valid   = r_out_valid;
    assign io_bus.out_result  = r_out_result;
    assign io_bus.out_timeout = r_out_timeout;
    assign io_bus.op_count    = r_op_count;
    assign io_bus.to_count    = r_to_count;

    assign o_dbg.state    = r_state;
    assign o_dbg.wait_cnt = w_wait_cnt;
    assign o_dbg.done_ok  = w_done_ok;
    assign o_dbg.timeout  = w_timeout;

endmodule

// File: tb/tb_fp_ci_issuer.sv
// Directed bench for fp_ci_issuer with a small behavioural FP-unit model
// whose done delay, result and stale-done behaviour are set per step.
module tb_fp_ci_issuer;
    import fp_ci_pkg::*;

    localparam int TO = 20;
    localparam int ML = 2;

    logic       clk = 1'b0;
    logic       reset_n;
    fp_ci_dbg_t dbg;

    fp_ci_issuer_if bus ();

    fp_ci_issuer #(
        .TIMEOUT_CYCLES (TO),
        .MIN_LAT        (ML)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .io_bus  (bus),
        .o_dbg   (dbg)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err    = 0;

    // FP unit model: done pulses um_delay falling edges after ci_start is seen
    // (negative = never); um_stale keeps done high with a stale result otherwise.
    int          um_delay     = -1;
    bit          um_stale     = 1'b0;
    logic [31:0] um_result    = '0;
    logic [31:0] um_stale_res = '0;
    int          um_cnt       = 0;
    bit          um_pend      = 1'b0;
    int          n_start      = 0;

    always @(negedge clk) begin
        if (!reset_n) begin
            um_pend = 1'b0;
        end else if (bus.ci_start === 1'b1) begin
            um_cnt  = um_delay;
            um_pend = 1'b1;
            n_start++;
        end else if (um_pend && um_cnt > 0) begin
            um_cnt--;
        end
        if (um_pend && bus.ci_start !== 1'b1 && um_cnt == 0) begin
            bus.ci_done   = 1'b1;
            bus.ci_result = um_result;
            um_pend       = 1'b0;
        end else if (um_stale) begin
            bus.ci_done   = 1'b1;
            bus.ci_result = um_stale_res;
        end else begin
            bus.ci_done   = 1'b0;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic offer(input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_dataa = a;
        bus.in_datab = b;
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_out(input int start, output int lat);
        lat = start;
        while (bus.out_valid !== 1'b1 && lat < 100) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic take();
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int          lat;
        int          starts;
        bit          saw_valid;
        logic [31:0] held;

        reset_n       = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_dataa  = '0;
        bus.in_datab  = '0;
        bus.out_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_ci_start", 32'(bus.ci_start), 32'd0);
        chk("rst_out_result", bus.out_result, 32'h0);
        chk("rst_out_timeout", 32'(bus.out_timeout), 32'd0);
        chk("rst_ci_dataa", bus.ci_dataa, 32'h0);
        chk("rst_ci_datab", bus.ci_datab, 32'h0);
        chk("rst_op_count", 32'(bus.op_count), 32'd0);
        chk("rst_to_count", 32'(bus.to_count), 32'd0);
        reset_n = 1'b1;
        @(negedge clk);
        chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
        chk("rst_state", 32'(dbg.state), 32'(ST_IDLE));

        // Normal op: done 10 cycles after start, 1.0 + 2.0 = 3.0.
        um_delay  = 10;
        um_result = 32'h4040_0000;
        offer(32'h3F80_0000, 32'h4000_0000);
        chk("a_ci_start_hi", 32'(bus.ci_start), 32'd1);
        chk("a_ci_dataa", bus.ci_dataa, 32'h3F80_0000);
        chk("a_ci_datab", bus.ci_datab, 32'h4000_0000);
        chk("a_in_ready_busy", 32'(bus.in_ready), 32'd0);
        @(negedge clk);
        chk("a_ci_start_lo", 32'(bus.ci_start), 32'd0);
        wait_out(1, lat);
        chk("a_latency", 32'(lat), 32'd11);
        chk("a_out_result", bus.out_result, 32'h4040_0000);
        chk("a_out_timeout", 32'(bus.out_timeout), 32'd0);
        chk("a_ci_dataa_held", bus.ci_dataa, 32'h3F80_0000);
        take();
        chk("a_op_count", 32'(bus.op_count), 32'd1);
        chk("a_to_count", 32'(bus.to_count), 32'd0);
        chk("a_start_pulses", 32'(n_start), 32'd1);
        chk("a_out_valid_lo", 32'(bus.out_valid), 32'd0);

        // Unit never answers: quiet NaN after TIMEOUT+2 cycles.
        um_delay = -1;
        offer(32'h4100_0000, 32'h4110_0000);
        wait_out(0, lat);
        chk("b_latency", 32'(lat), 32'(TO + 2));
        chk("b_out_result", bus.out_result, 32'h7FC0_0000);
        chk("b_out_timeout", 32'(bus.out_timeout), 32'd1);
        take();
        chk("b_op_count", 32'(bus.op_count), 32'd2);
        chk("b_to_count", 32'(bus.to_count), 32'd1);

        // Stale done high in IDLE has no effect, then is ignored for MIN_LAT cycles.
        um_stale_res = 32'hDEAD_BEEF;
        um_stale     = 1'b1;
        repeat (3) @(negedge clk);
        chk("c_idle_no_valid", 32'(bus.out_valid), 32'd0);
        chk("c_idle_state", 32'(dbg.state), 32'(ST_IDLE));
        um_delay  = 3;
        um_result = 32'h4120_0000;
        offer(32'h3F00_0000, 32'h3E80_0000);
        wait_out(0, lat);
        chk("c_latency", 32'(lat), 32'(ML + 2));
        chk("c_out_result", bus.out_result, 32'h4120_0000);
        chk("c_out_timeout", 32'(bus.out_timeout), 32'd0);
        @(negedge clk);
        chk("c_hold_stable", bus.out_result, 32'h4120_0000);
        take();
        um_stale = 1'b0;
        chk("c_op_count", 32'(bus.op_count), 32'd3);

        // Consumer stalls 50 cycles in HOLD while a new operand pair is offered.
        um_delay  = 5;
        um_result = 32'h40A0_0000;
        offer(32'h4080_0000, 32'h3F80_0000);
        wait_out(0, lat);
        chk("d_latency", 32'(lat), 32'd6);
        held   = bus.out_result;
        starts = n_start;
        for (int i = 0; i < 50; i++) begin
            bus.in_valid = 1'b1;
            bus.in_dataa = 32'h1234_0000 + 32'(i);
            bus.in_datab = 32'h5678_0000;
            @(negedge clk);
            chk("d_hold_result", bus.out_result, 32'h40A0_0000);
            chk("d_hold_in_ready", 32'(bus.in_ready), 32'd0);
            chk("d_hold_valid", 32'(bus.out_valid), 32'd1);
        end
        bus.in_valid = 1'b0;
        chk("d_held_before", held, 32'h40A0_0000);
        chk("d_no_new_start", 32'(n_start), 32'(starts));
        chk("d_ci_dataa_kept", bus.ci_dataa, 32'h4080_0000);
        take();
        chk("d_op_count", 32'(bus.op_count), 32'd4);
        chk("d_out_valid_lo", 32'(bus.out_valid), 32'd0);
        @(negedge clk);
        chk("d_in_ready_back", 32'(bus.in_ready), 32'd1);

        // Reset during WAIT abandons the op; next op runs normally.
        um_delay  = 10;
        um_result = 32'h4200_0000;
        offer(32'h4000_0000, 32'h4000_0000);
        repeat (4) @(negedge clk);
        chk("e_in_wait", 32'(dbg.state), 32'(ST_WAIT));
        reset_n = 1'b0;
        #1;
        chk("e_rst_state", 32'(dbg.state), 32'(ST_IDLE));
        chk("e_rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("e_rst_op_count", 32'(bus.op_count), 32'd0);
        chk("e_rst_to_count", 32'(bus.to_count), 32'd0);
        chk("e_rst_ci_dataa", bus.ci_dataa, 32'h0);
        chk("e_rst_out_result", bus.out_result, 32'h0);
        starts = n_start;
        @(negedge clk);
        @(negedge clk);
        reset_n   = 1'b1;
        saw_valid = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (bus.out_valid === 1'b1) saw_valid = 1'b1;
        end
        chk("e_no_out_valid", 32'(saw_valid), 32'd0);
        chk("e_no_start", 32'(n_start), 32'(starts));
        um_delay  = 3;
        um_result = 32'h40E0_0000;
        offer(32'h4040_0000, 32'h4080_0000);
        wait_out(0, lat);
        chk("e_latency", 32'(lat), 32'd4);
        chk("e_out_result", bus.out_result, 32'h40E0_0000);
        take();
        chk("e_op_count", 32'(bus.op_count), 32'd1);

        // Done arrives on exactly the timeout cycle: real result wins.
        um_delay  = TO + 1;
        um_result = 32'h4100_0000;
        offer(32'h40A0_0000, 32'h4040_0000);
        wait_out(0, lat);
        chk("f_latency", 32'(lat), 32'(TO + 2));
        chk("f_out_result", bus.out_result, 32'h4100_0000);
        chk("f_out_timeout", 32'(bus.out_timeout), 32'd0);
        take();
        chk("f_op_count", 32'(bus.op_count), 32'd2);
        chk("f_to_count", 32'(bus.to_count), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/fp_ci_issuer.md
FP_CI_ISSUER -- requirements
Module: fp_ci_issuer

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 255, max cycles waited for ci_done after ci_start.
REQ-002 Parameter MIN_LAT, default 2, cycles after ci_start before ci_done is honoured.
REQ-003 clk  in  1  sole clock, all state updates on rising edge.
REQ-004 reset_n  in  1  reset; one clock, reset is asynchronous and active-low.
REQ-005 in_valid  in  1  operand pair offered.
REQ-006 in_ready  out  1  issuer accepts operand pair this cycle.
REQ-007 in_dataa, in_datab  in  32 each  IEEE-754 single operands.
REQ-008 ci_start  out  1  single-cycle start pulse to the multi-cycle FP unit.
REQ-009 ci_dataa, ci_datab  out  32 each  operands to the FP unit.
REQ-010 ci_result  in  32  FP unit result.
REQ-011 ci_done  in  1  FP unit result valid (level or pulse).
REQ-012 out_valid  out  1  result available.
REQ-013 out_ready  in  1  consumer accepts result.
REQ-014 out_result  out  32  captured result.
REQ-015 out_timeout  out  1  qualifies out_result: 1 = unit never signalled done.
REQ-016 op_count, to_count  out  16 each  completed operations, timed-out operations.

Function
REQ-017 FSM states IDLE, ISSUE, WAIT, HOLD; single-hot encoding not required.
REQ-018 IDLE: in_ready=1; on in_valid, operands latch into ci_dataa/ci_datab, go ISSUE.
REQ-019 ISSUE: ci_start=1 for exactly this one cycle, wait counter cleared, go WAIT.
REQ-020 ci_dataa/ci_datab held constant from ISSUE until HOLD exits; the unit samples operands continuously.
REQ-021 WAIT: counter increments each cycle; ci_done ignored while counter < MIN_LAT (stale done from prior op).
REQ-022 WAIT, counter >= MIN_LAT and ci_done=1: ci_result captured to out_result, out_timeout=0, go HOLD.
REQ-023 WAIT, counter reaches TIMEOUT_CYCLES without accepted done: out_result=32'h7FC00000 (quiet NaN), out_timeout=1, go HOLD.
REQ-024 Done and timeout in same cycle: done wins, out_timeout=0.
REQ-025 HOLD: out_valid=1; out_result/out_timeout stable until out_valid&out_ready; then go IDLE.
REQ-026 in_ready=0 in ISSUE, WAIT, HOLD; latency in_valid accept -> out_valid = MIN_LAT..TIMEOUT_CYCLES + 2 cycles.
REQ-027 Back-to-back: HOLD handshake and next in_valid accepted no earlier than following IDLE cycle (one op in flight max).
REQ-028 op_count increments on every HOLD handshake; to_count on handshakes with out_timeout=1; both wrap at 16'hFFFF -> 0.
REQ-029 ci_done asserted in IDLE/HOLD has no effect.

Reset
REQ-030 reset_n low: state IDLE, ci_start=0, out_valid=0, in_ready=1 after release, out_timeout=0, out_result=0, ci_dataa=ci_datab=0, counters=0.
REQ-031 Reset mid-operation (any state) abandons the op without producing output; no ci_start issued in the cycle reset releases.

Structure
REQ-032 Shared package fp_ci_pkg holds state enum, FP_QNAN constant 32'h7FC00000, FP width 32.
REQ-033 One sub-module natural: fp_ci_wait_timer (counter, MIN_LAT gate, timeout flag); rest flat.

Verification
REQ-034 Model unit with done after 10 cycles, dataa=3F800000, datab=40000000, result 40400000 -> one ci_start pulse, out_result=40400000, out_timeout=0, op_count=1.
REQ-035 Unit never asserts done, TIMEOUT_CYCLES=20 -> out_valid 22 cycles after accept, out_result=7FC00000, out_timeout=1, to_count=1.
REQ-036 ci_done held high from previous op at start -> ignored for MIN_LAT cycles; result captured only afterwards.
REQ-037 out_ready held low 50 cycles in HOLD -> out_result stable, in_ready=0, in_valid ignored; release -> one handshake.
REQ-038 reset_n pulsed low during WAIT -> out_valid never asserts for that op, counters 0, next op completes normally.
REQ-039 Done exactly on timeout cycle -> out_timeout=0, real result delivered.
